// File: rtl/weight_loader_param.sv
// Streams per-channel weight vectors out of a packed-word ROM into a PE bus.
// Each output channel is assembled from WPC consecutive ROM words, then held until the PE accepts it.
module weight_loader_param #(
    parameter int W_BITS = 7,
    parameter int WPW    = 4,
    parameter int LANES  = 16,
    parameter int N_OCH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [$clog2(N_OCH+1)-1:0]   n_och,
    output logic                         rom_en,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [W_BITS*WPW-1:0]        rom_data,
    output logic [LANES*W_BITS-1:0]      w_bus,
    output logic                         w_valid,
    input  logic                         pe_ready,
    output logic [$clog2(N_OCH)-1:0]     och_idx,
    output logic [N_OCH-1:0]             och_loaded,
    output logic                         busy,
    output logic                         done
);

    localparam int WPC    = LANES / WPW;
    localparam int WORD_W = W_BITS * WPW;
    localparam int NOCH_W = $clog2(N_OCH + 1);
    localparam int IDX_W  = $clog2(N_OCH);
    localparam int CNT_W  = $clog2(WPC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_q,      state_d;
    logic                     rom_en_q,     rom_en_d;
    logic [ADDR_W-1:0]        rom_addr_q,   rom_addr_d;
    logic                     rd_vld_q,     rd_vld_d;
    logic [CNT_W-1:0]         iss_q,        iss_d;
    logic [CNT_W-1:0]         cap_q,        cap_d;
    logic [LANES*W_BITS-1:0]  w_bus_q,      w_bus_d;
    logic                     w_valid_q,    w_valid_d;
    logic [IDX_W-1:0]         och_idx_q,    och_idx_d;
    logic [N_OCH-1:0]         och_loaded_q, och_loaded_d;
    logic [NOCH_W-1:0]        n_och_q,      n_och_d;

    logic [NOCH_W-1:0]        n_och_clamp;
    logic [NOCH_W-1:0]        och_next;

    assign n_och_clamp = (n_och > NOCH_W'(N_OCH)) ? NOCH_W'(N_OCH) : n_och;
    assign och_next    = NOCH_W'(och_idx_q) + NOCH_W'(1);

    always_comb begin
        state_d      = state_q;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        rd_vld_d     = rom_en_q;
        iss_d        = iss_q;
        cap_d        = cap_q;
        w_bus_d      = w_bus_q;
        w_valid_d    = w_valid_q;
        och_idx_d    = och_idx_q;
        och_loaded_d = och_loaded_q;
        n_och_d      = n_och_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    och_loaded_d = '0;
                    och_idx_d    = '0;
                    n_och_d      = n_och_clamp;
                    if (n_och_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = FETCH;
                        rom_en_d   = 1'b1;
                        rom_addr_d = base_addr;
                        iss_d      = CNT_W'(1);
                        cap_d      = '0;
                    end
                end
            end

            FETCH: begin
                if (iss_q < CNT_W'(WPC)) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    iss_d      = iss_q + CNT_W'(1);
                end
                // rd_vld_q marks the cycle the ROM word requested last cycle is on rom_data
                if (rd_vld_q) begin
                    for (int k = 0; k < WPC; k++) begin
                        if (cap_q == CNT_W'(k)) begin
                            w_bus_d[(WPC-1-k)*WORD_W +: WORD_W] = rom_data;
                        end
                    end
                    cap_d = cap_q + CNT_W'(1);
                    if (cap_q == CNT_W'(WPC - 1)) begin
                        state_d   = HOLD;
                        w_valid_d = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (w_valid_q && pe_ready) begin
                    och_loaded_d[och_idx_q] = 1'b1;
                    w_valid_d = 1'b0;
                    och_idx_d = och_idx_q + IDX_W'(1);
                    if (och_next < n_och_q) begin
                        state_d    = FETCH;
                        rom_en_d   = 1'b1;
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        iss_d      = CNT_W'(1);
                        cap_d      = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            rd_vld_q     <= 1'b0;
            iss_q        <= '0;
            cap_q        <= '0;
            w_bus_q      <= '0;
            w_valid_q    <= 1'b0;
            och_idx_q    <= '0;
            och_loaded_q <= '0;
            n_och_q      <= '0;
        end else begin
            state_q      <= state_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            rd_vld_q     <= rd_vld_d;
            iss_q        <= iss_d;
            cap_q        <= cap_d;
            w_bus_q      <= w_bus_d;
            w_valid_q    <= w_valid_d;
            och_idx_q    <= och_idx_d;
            och_loaded_q <= och_loaded_d;
            n_och_q      <= n_och_d;
        end
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign w_bus      = w_bus_q;
    assign w_valid    = w_valid_q;
    assign och_idx    = och_idx_q;
    assign och_loaded = och_loaded_q;
    assign busy       = (state_q == FETCH) || (state_q == HOLD);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_weight_loader_param.sv
// Scoreboard bench for weight_loader_param: expected ROM addresses and channel vectors are
// queued when a load is started and checked as the DUT issues reads and transfers channels.
module tb_weight_loader_param;

    localparam int W_BITS = 7;
    localparam int WPW    = 4;
    localparam int LANES  = 16;
    localparam int N_OCH  = 32;
    localparam int ADDR_W = 10;
    localparam int WPC    = LANES / WPW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [ADDR_W-1:0]       base_addr;
    logic [5:0]              n_och;
    logic                    rom_en;
    logic [ADDR_W-1:0]       rom_addr;
    logic [W_BITS*WPW-1:0]   rom_data;
    logic [LANES*W_BITS-1:0] w_bus;
    logic                    w_valid;
    logic                    pe_ready;
    logic [4:0]              och_idx;
    logic [N_OCH-1:0]        och_loaded;
    logic                    busy;
    logic                    done;

    weight_loader_param #(
        .W_BITS(W_BITS), .WPW(WPW), .LANES(LANES), .N_OCH(N_OCH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_och(n_och),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .w_bus(w_bus), .w_valid(w_valid), .pe_ready(pe_ready), .och_idx(och_idx),
        .och_loaded(och_loaded), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W_BITS*WPW-1:0] rom_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    typedef struct packed {
        logic [4:0]              idx;
        logic [LANES*W_BITS-1:0] bus;
    } chan_t;

    chan_t             chan_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int checks = 0;
    int errors = 0;

    // Expected reads and lane-by-lane channel images for one load
    task push_load(input int base, input int n);
        chan_t             e;
        logic [ADDR_W-1:0] a;
        logic [W_BITS*WPW-1:0] word;
        int lane;
        for (int c = 0; c < n; c++) begin
            e.idx = 5'(c);
            e.bus = '0;
            for (int k = 0; k < WPC; k++) begin
                a = ADDR_W'(base + c*WPC + k);
                addr_q.push_back(a);
                word = rom_mem[a];
                for (int j = 0; j < WPW; j++) begin
                    lane = k*WPW + j;
                    e.bus[(LANES-1-lane)*W_BITS +: W_BITS] = word[(WPW-1-j)*W_BITS +: W_BITS];
                end
            end
            chan_q.push_back(e);
        end
    endtask

    // One clock: scoreboard observation at the falling edge, return just after the rising edge
    task step();
        logic [ADDR_W-1:0] ea;
        chan_t ec;
        @(negedge clk);
        if (!rst) begin
            if (rom_en) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rom_read unexpected: got addr=%0d, required no read", rom_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (rom_addr !== ea) begin
                        errors++;
                        $display("FAIL rom_addr got=%0d required=%0d", rom_addr, ea);
                    end
                end
            end
            if (w_valid && pe_ready) begin
                checks++;
                if (chan_q.size() == 0) begin
                    errors++;
                    $display("FAIL transfer unexpected: got och_idx=%0d, required none", och_idx);
                end else begin
                    ec = chan_q.pop_front();
                    if (och_idx !== ec.idx || w_bus !== ec.bus) begin
                        errors++;
                        $display("FAIL transfer got idx=%0d bus=%h required idx=%0d bus=%h",
                                 och_idx, w_bus, ec.idx, ec.bus);
                    end else begin
                        $display("transfer och_idx=%0d bus=%h", och_idx, w_bus);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task do_start(input int base, input int n);
        int exp_n;
        exp_n     = (n > N_OCH) ? N_OCH : n;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        n_och     = 6'(n);
        push_load(base, exp_n);
        step();
        start = 1'b0;
    endtask

    task wait_done(input string name, input int limit);
        int cnt;
        cnt = 0;
        while (!done && cnt < limit) begin
            step();
            cnt++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done timeout: got done=%0b after %0d cycles, required 1", name, done, cnt);
        end
    endtask

    task check_drained(input string name);
        checks++;
        if (addr_q.size() != 0 || chan_q.size() != 0) begin
            errors++;
            $display("FAIL %s drained: got %0d reads %0d channels pending, required 0 0",
                     name, addr_q.size(), chan_q.size());
        end
    endtask

    task check_loaded(input string name, input logic [N_OCH-1:0] exp);
        checks++;
        if (och_loaded !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s och_loaded got=%h busy=%0b required=%h busy=0", name, och_loaded, busy, exp);
        end else begin
            $display("%s och_loaded=%h done=%0b", name, och_loaded, done);
        end
    endtask

    task test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({rom_en, rom_addr, w_bus, w_valid, och_idx, och_loaded, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%0b addr=%0d valid=%0b idx=%0d loaded=%h busy=%0b done=%0b required all 0",
                     rom_en, rom_addr, w_valid, och_idx, och_loaded, busy, done);
        end
        rst = 1'b0;
        step();
        do_start(5, 2);
        step();
        step();
        checks++;
        if (busy !== 1'b1 || rom_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefetch got busy=%0b rom_en=%0b required 1 1", busy, rom_en);
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        addr_q.delete();
        chan_q.delete();
        checks++;
        if ({rom_en, rom_addr, w_bus, w_valid, och_idx, och_loaded, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_midfetch got en=%0b addr=%0d valid=%0b idx=%0d busy=%0b done=%0b required all 0",
                     rom_en, rom_addr, w_valid, och_idx, busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (w_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_abandon cycle %0d got w_valid=%0b busy=%0b required 0 0", i, w_valid, busy);
            end
        end
        $display("reset test complete");
    endtask

    task test_normal();
        int first;
        int en_cnt;
        pe_ready = 1'b1;
        do_start(0, 2);
        first  = 0;
        en_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            if (w_valid && first == 0) first = i;
            if (rom_en && i <= 6) en_cnt++;
            step();
        end
        checks++;
        if (first != 6 || en_cnt != WPC) begin
            errors++;
            $display("FAIL normal_latency got first_valid=%0d reads=%0d required 6 %0d", first, en_cnt, WPC);
        end
        wait_done("normal", 200);
        check_loaded("normal", 32'h3);
        check_drained("normal");
    endtask

    task test_backpressure();
        logic [LANES*W_BITS-1:0] bus0;
        logic [4:0] idx0;
        int cnt;
        pe_ready = 1'b0;
        do_start(100, 2);
        cnt = 0;
        while (!w_valid && cnt < 20) begin
            step();
            cnt++;
        end
        checks++;
        if (!w_valid) begin
            errors++;
            $display("FAIL bp_valid timeout: got w_valid=0, required 1");
        end
        bus0 = w_bus;
        idx0 = och_idx;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (w_valid !== 1'b1 || w_bus !== bus0 || och_idx !== idx0 || rom_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%0b idx=%0d rom_en=%0b bus=%h required 1 %0d 0 %h",
                         i, w_valid, och_idx, rom_en, w_bus, idx0, bus0);
            end
        end
        pe_ready = 1'b1;
        step();
        checks++;
        if (w_valid !== 1'b0 || rom_en !== 1'b1 || och_loaded !== 32'h1 || och_idx !== 5'd1) begin
            errors++;
            $display("FAIL bp_release got valid=%0b rom_en=%0b loaded=%h idx=%0d required 0 1 1 1",
                     w_valid, rom_en, och_loaded, och_idx);
        end
        wait_done("backpressure", 200);
        check_loaded("backpressure", 32'h3);
        check_drained("backpressure");
    endtask

    task test_empty();
        do_start(0, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rom_en !== 1'b0 || och_loaded !== '0) begin
            errors++;
            $display("FAIL empty got done=%0b busy=%0b rom_en=%0b loaded=%h required 1 0 0 0",
                     done, busy, rom_en, och_loaded);
        end
        for (int i = 0; i < 4; i++) step();
        check_loaded("empty", 32'h0);
    endtask

    task test_wrap();
        pe_ready = 1'b1;
        do_start(1022, 1);
        wait_done("wrap", 200);
        check_loaded("wrap", 32'h1);
        check_drained("wrap");
    endtask

    task test_back_to_back();
        int cnt;
        pe_ready = 1'b1;
        do_start(0, 5);
        step();
        step();
        start     = 1'b1;
        base_addr = ADDR_W'(500);
        n_och     = 6'd3;
        step();
        start = 1'b0;
        wait_done("ignore_start", 300);
        check_loaded("ignore_start", 32'h1F);
        check_drained("ignore_start");

        do_start(200, 32);
        checks++;
        if (och_loaded !== '0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear got loaded=%h done=%0b busy=%0b required 0 0 1", och_loaded, done, busy);
        end
        wait_done("restart_full", 1000);
        check_loaded("restart_full", 32'hFFFF_FFFF);
        check_drained("restart_full");

        do_start(10, 45);
        cnt = 0;
        while (!done && cnt < 3000) begin
            pe_ready = 1'($urandom_range(0, 1));
            step();
            cnt++;
        end
        pe_ready = 1'b1;
        wait_done("clamp", 10);
        check_loaded("clamp", 32'hFFFF_FFFF);
        check_drained("clamp");
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) rom_mem[a] = 28'($urandom);
        rst       = 1'b1;
        start     = 1'b0;
        pe_ready  = 1'b0;
        base_addr = '0;
        n_och     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_normal();
        test_backpressure();
        test_empty();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
